mips_divider: RTL
=================

# mips_divider

Multi-cycle radix-2 restoring divider for the MIPS `div`/`divu` instructions. It sits directly upstream of the execute-stage HI/LO ALU: the quotient is written to LO and the remainder to HI. It accepts a start pulse from the execute stage and raises `busy` while it iterates, which the hazard unit uses to stall `mfhi`/`mflo`. It produces a one-cycle `done` pulse with the results held stable until the next accepted start.

## Interface
Parameters:
- `DATA_W`, 32, operand and result width (≥2)

Ports:
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a divide; accepted only when `busy`=0
- `signed_op`  in  1  1 = `div` (two's complement), 0 = `divu`; sampled with `start`
- `data1`  in  DATA_W  dividend; sampled with `start`
- `data2`  in  DATA_W  divisor; sampled with `start`
- `cancel`  in  1  pipeline flush; aborts the operation in flight
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse; `quot`/`rem`/`div_zero` are valid from this cycle on
- `quot`  out  DATA_W  quotient (to LO)
- `rem`  out  DATA_W  remainder (to HI)
- `div_zero`  out  1  the last completed operation had divisor 0

## Operation
- States:
  - IDLE → PREP on an accepted `start`.
  - PREP → ITER.
  - ITER stays for DATA_W edges (down-counter DATA_W-1..0), then → FIX.
  - FIX → IDLE; `done` is registered on this edge.
- PREP:
  - If `signed_op` is set, take the absolute value of each operand as an unsigned DATA_W-bit value.
  - Latch the result signs: quotient sign = sign1 XOR sign2; remainder sign = sign1.
  - Latch divisor==0 and the raw dividend.
- ITER, one restoring step per edge:
  - partial = {rem_acc[DATA_W-2:0], q_acc[DATA_W-1]}.
  - Trial subtract the divisor at DATA_W+1 bits. If non-negative, keep the difference and shift in 1; otherwise keep partial and shift in 0.
- FIX:
  - Negate the quotient and/or remainder according to the latched signs.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
- Overflow (most-negative / -1) gives quot = most-negative and rem = 0. This falls out of the DATA_W-bit arithmetic and needs no special case.
- Divisor 0: quot = all ones, rem = raw dividend, `div_zero`=1. Full latency is still taken.
- Outputs `quot`, `rem` and `div_zero` update only on the FIX→IDLE edge. They hold until the next completion.

## Timing
- Reset value of every output is 0. `reset_n` low forces IDLE immediately (asynchronous), mid-operation included; no `done` is produced for the aborted operation.
- Latency: `start` is sampled at edge 0; `done`=1 in the cycle after edge DATA_W+2, i.e. DATA_W+2 cycles after the start edge.
- `busy`:
  - Goes to 1 on edge 0.
  - Goes to 0 on the same edge that raises `done`.
  - A `start` in the `done` cycle is accepted (back-to-back operation).
- `start` while `busy`=1 is ignored: no restart and no effect on the operands.
- `cancel` is synchronous. While `busy`=1 it forces IDLE on the next edge, with no `done` and outputs unchanged. In IDLE it has no effect.
- `cancel` and `start` in the same cycle: `cancel` wins and nothing is accepted.
- `done` is never high for two consecutive cycles.

## Structure
- Shared package / header:
  - state encoding type (IDLE, PREP, ITER, FIX)
  - `Mips_divider_W` default constant
  - the `div`/`divu` ALU function codes that drive `start`/`signed_op`
- Sub-module `mips_divider_step`: combinational single restoring step. Inputs are the partial remainder, quotient and divisor; outputs are the next remainder, next quotient and the quotient bit.
- Top level holds the FSM, the iteration counter, operand/sign latches and output registers.

## Test plan (DATA_W=4)
- Unsigned 4'h7 / 4'h3 → quot 4'h2, rem 4'h1, div_zero 0; `done` exactly 6 cycles after the start edge; `busy` high for 6 cycles.
- Signed 4'h9 (-7) / 4'h2 → quot 4'hd (-3), rem 4'hf (-1). Signed 4'h7 / 4'he (-2) → quot 4'hd, rem 4'h1.
- Signed 4'h8 / 4'hf → quot 4'h8, rem 4'h0. Unsigned 4'h8 / 4'hf → quot 4'h0, rem 4'h8.
- 4'ha / 4'h0 (either signedness) → quot 4'hf, rem 4'ha, div_zero 1, same 6-cycle latency.
- Scenario A: start 4'hf/4'h2, then pulse `start` with 4'h1/4'h1 at cycle 2 → ignored; result is quot 4'h7, rem 4'h1. Scenario B: `start` again in the `done` cycle → accepted; second `done` 6 cycles later.
- Assert `cancel` at cycle 3 → `busy` 0 next cycle, no `done`, outputs keep their prior values. Drop `reset_n` at cycle 4 of a new operation → all outputs 0 immediately; after release, a fresh 4'h6 / 4'h4 gives quot 4'h1, rem 4'h2.

Source files
------------

// File: rtl/mips_divider_pkg.sv
// Shared types and constants for the multi-cycle div/divu unit.
package mips_divider_pkg;

  // Default operand width for the MIPS integer datapath.
  localparam int Mips_divider_W = 32;

  // Divider sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_ITER = 2'd2,
    ST_FIX  = 2'd3
  } div_state_t;

  // SPECIAL-opcode function codes that raise start; DIV also sets signed_op.
  localparam logic [5:0] FUNCT_DIV  = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU = 6'h1b;

endpackage

// File: rtl/mips_divider_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference when it fits.
module mips_divider_step
  import mips_divider_pkg::*;
#(
  parameter int DATA_W = Mips_divider_W
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] quot_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic [DATA_W-1:0] quot_out,
  output logic              q_bit
);

  logic [DATA_W-1:0] partial;
  logic [DATA_W:0]   diff;
  // The running remainder is always below 2^(DATA_W-1) before a shift, so its
  // top bit carries no information and is dropped.
  logic              unused_rem_msb;

  assign unused_rem_msb = rem_in[DATA_W-1];
  assign partial        = {rem_in[DATA_W-2:0], quot_in[DATA_W-1]};
  assign diff           = {1'b0, partial} - {1'b0, divisor};
  assign q_bit          = ~diff[DATA_W];
  assign rem_out        = q_bit ? diff[DATA_W-1:0] : partial;
  assign quot_out       = {quot_in[DATA_W-2:0], q_bit};

endmodule

// File: rtl/mips_divider.sv
// Multi-cycle radix-2 restoring divider for MIPS div/divu; quot feeds LO and
// rem feeds HI. Results hold until the next completed operation.
//
// state   | meaning
// IDLE    | waiting for start; results held
// PREP    | take operand magnitudes, latch result signs and divisor==0
// ITER    | one restoring step per edge, DATA_W edges
// FIX     | apply signs / divide-by-zero result, pulse done
module mips_divider
  import mips_divider_pkg::*;
#(
  parameter int DATA_W = Mips_divider_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              signed_op,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic              cancel,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem,
  output logic              div_zero
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  div_state_t        state, state_nxt;
  logic              accept, finish;
  logic [CNT_W-1:0]  cnt;
  logic              op_signed, neg_q, neg_r, dz;
  logic [DATA_W-1:0] dvd_raw, dvs_raw, divisor;
  logic [DATA_W-1:0] q_acc, rem_acc;
  logic [DATA_W-1:0] step_rem, step_quot;
  logic              step_qbit_unused;
  logic [DATA_W-1:0] quot_fin, rem_fin;

  mips_divider_step #(.DATA_W(DATA_W)) u_step (
    .rem_in   (rem_acc),
    .quot_in  (q_acc),
    .divisor  (divisor),
    .rem_out  (step_rem),
    .quot_out (step_quot),
    .q_bit    (step_qbit_unused)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state; cancel beats both a new start and a pending completion.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: if (start && !cancel) begin
        state_nxt = ST_PREP;
        accept    = 1'b1;
      end
      ST_PREP: state_nxt = cancel ? ST_IDLE : ST_ITER;
      ST_ITER: begin
        if (cancel)             state_nxt = ST_IDLE;
        else if (cnt == '0)     state_nxt = ST_FIX;
      end
      ST_FIX: begin
        state_nxt = ST_IDLE;
        finish    = !cancel;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Final result: divide-by-zero returns all ones / raw dividend, else signs fixed up.
  always_comb begin
    quot_fin = neg_q ? -q_acc : q_acc;
    rem_fin  = neg_r ? -rem_acc : rem_acc;
    if (dz) begin
      quot_fin = '1;
      rem_fin  = dvd_raw;
    end
  end

  // Operand latches and iteration datapath.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_signed <= 1'b0;
      dvd_raw   <= '0;
      dvs_raw   <= '0;
      divisor   <= '0;
      q_acc     <= '0;
      rem_acc   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz        <= 1'b0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        op_signed <= signed_op;
        dvd_raw   <= data1;
        dvs_raw   <= data2;
      end
      if (state == ST_PREP) begin
        q_acc   <= (op_signed && dvd_raw[DATA_W-1]) ? -dvd_raw : dvd_raw;
        divisor <= (op_signed && dvs_raw[DATA_W-1]) ? -dvs_raw : dvs_raw;
        rem_acc <= '0;
        neg_q   <= op_signed && (dvd_raw[DATA_W-1] ^ dvs_raw[DATA_W-1]);
        neg_r   <= op_signed && dvd_raw[DATA_W-1];
        dz      <= (dvs_raw == '0);
        cnt     <= CNT_W'(DATA_W - 1);
      end
      if (state == ST_ITER) begin
        q_acc   <= step_quot;
        rem_acc <= step_rem;
        cnt     <= cnt - CNT_W'(1);
      end
    end
  end

  // Result registers change only on a completing edge; done is a single pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done     <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        quot     <= quot_fin;
        rem      <= rem_fin;
        div_zero <= dz;
      end
    end
  end

endmodule
